// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: default sizing and
// the FSM state encoding.
package int_pkg;

    localparam int N_SRC_DEF = 8;
    localparam int ID_W_DEF  = 3;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_REQ     = S_REQ,
        ST_SERVICE = S_SERVICE
    } state_t;

endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder: the lowest set index wins.
module prio_enc #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic [N_SRC-1:0] req,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    // hit is one-hot: a request with no request at any lower index
    logic [N_SRC-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_hit
            if (gi == 0) begin : g_first
                assign hit[gi] = req[gi];
            end else begin : g_rest
                assign hit[gi] = req[gi] & ~(|req[gi-1:0]);
            end
        end
    endgenerate

    // Convert the one-hot winner into its binary index
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (hit[i]) begin
                idx = ID_W'(i);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge capture into pending bits, masking,
// fixed priority selection and a non-nesting request/service handshake.
module int_ctrl
    import int_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             int_ack,
    input  logic             eoi,
    output logic             INT,
    output logic [ID_W-1:0]  int_id,
    output logic [N_SRC-1:0] pending,
    output logic             in_service
);

    state_t           state_q, state_d;
    logic [N_SRC-1:0] irq_prev_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [ID_W-1:0]  int_id_q, int_id_d;

    logic [N_SRC-1:0] edge_vec;
    logic [N_SRC-1:0] clr_vec;
    logic [ID_W-1:0]  win_id;
    logic             win_valid;

    assign edge_vec = irq_in & ~irq_prev_q;

    prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req   (pending_q & ~mask_q),
        .idx   (win_id),
        .valid (win_valid)
    );

    // Next-state logic; int_id only changes when leaving IDLE, so it stays
    // frozen for the whole request and service.
    always_comb begin
        state_d  = state_q;
        int_id_d = int_id_q;
        clr_vec  = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    int_id_d = win_id;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    clr_vec = {{(N_SRC-1){1'b0}}, 1'b1} << int_id_q;
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pending and mask updates; a fresh edge beats the acknowledge clear,
    // and a mask write is only seen by arbitration from the next cycle.
    always_comb begin
        pending_d = (pending_q & ~clr_vec) | edge_vec;
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    // State registers; reset leaves every source masked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '1;
            int_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_in;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            int_id_q   <= int_id_d;
        end
    end

    assign INT        = (state_q == ST_REQ);
    assign in_service = (state_q == ST_SERVICE);
    assign int_id     = int_id_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_int_ctrl;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq_in;
    logic         mask_we;
    logic [N-1:0] mask_wdata;
    logic         int_ack;
    logic         eoi;
    logic         INT;
    logic [W-1:0] int_id;
    logic [N-1:0] pending;
    logic         in_service;

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 0;

    int_ctrl #(.N_SRC(N), .ID_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .INT        (INT),
        .int_id     (int_id),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    // Model: what the controller must look like after each clock edge
    bit [N-1:0] m_pend, m_prev, m_mask;
    int         m_phase;   // 0 waiting, 1 requesting, 2 handler running
    int         m_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_prev  = '0;
        m_mask  = '1;
        m_phase = 0;
        m_id    = 0;
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled
    task automatic model_step();
        bit [N-1:0] rising;
        bit [N-1:0] live;
        rising = irq_in & ~m_prev;
        live   = m_pend & ~m_mask;
        if (m_phase == 0) begin
            if (live != 0) begin
                for (int i = N - 1; i >= 0; i--) if (live[i]) m_id = i;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (int_ack) begin
                m_pend[m_id] = 1'b0;
                m_phase = 2;
            end
        end else begin
            if (eoi) m_phase = 0;
        end
        m_pend = m_pend | rising;
        if (mask_we) m_mask = mask_wdata;
        m_prev = irq_in;
    endtask

    // Per-cycle comparison against the model, then model advance
    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (done) break;
            if (rst) begin
                model_reset();
            end else begin
                check("m_INT", 32'(INT), 32'(m_phase == 1));
                check("m_in_service", 32'(in_service), 32'(m_phase == 2));
                check("m_pending", 32'(pending), 32'(m_pend));
                if (m_phase == 1) check("m_int_id", 32'(int_id), 32'(m_id));
                model_step();
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1; cyc(); eoi = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
        int_ack = 1'b0; eoi = 1'b0;
        fork
            compare_loop();
        join_none

        // Reset state, then unmasked source 0
        cyc(); cyc();
        check("rst_INT", 32'(INT), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_in_service", 32'(in_service), 32'd0);
        check("rst_int_id", 32'(int_id), 32'd0);
        rst = 1'b0;
        mask_we = 1'b1; mask_wdata = 8'hFE; cyc(); mask_we = 1'b0;
        irq_in = 8'h01; cyc();
        check("t1_pending", 32'(pending), 32'h01);
        check("t1_INT_early", 32'(INT), 32'd0);
        cyc();
        check("t1_INT", 32'(INT), 32'd1);
        check("t1_int_id", 32'(int_id), 32'd0);
        pulse_ack();
        check("t1_ack_INT", 32'(INT), 32'd0);
        check("t1_ack_pending", 32'(pending), 32'h00);
        check("t1_ack_in_service", 32'(in_service), 32'd1);
        pulse_eoi(); irq_in = '0;
        check("t1_eoi_in_service", 32'(in_service), 32'd0);

        // Reset mask holds a request off until unmasked
        rst = 1'b1; cyc(); rst = 1'b0;
        irq_in = 8'h08; cyc();
        check("t2_pending", 32'(pending), 32'h08);
        cyc(); cyc();
        check("t2_masked_INT", 32'(INT), 32'd0);
        mask_we = 1'b1; mask_wdata = 8'h00; cyc(); mask_we = 1'b0;
        check("t2_old_mask_INT", 32'(INT), 32'd0);
        cyc();
        check("t2_INT", 32'(INT), 32'd1);
        check("t2_int_id", 32'(int_id), 32'd3);
        pulse_ack(); pulse_eoi(); irq_in = '0;

        // Simultaneous sources 5 and 2
        irq_in = 8'h24; cyc(); cyc();
        check("t3_first_id", 32'(int_id), 32'd2);
        pulse_ack(); pulse_eoi();
        check("t3_gap_INT", 32'(INT), 32'd0);
        cyc();
        check("t3_second_INT", 32'(INT), 32'd1);
        check("t3_second_id", 32'(int_id), 32'd5);
        pulse_ack(); pulse_eoi(); irq_in = '0; cyc();

        // Higher-priority edge does not preempt a presented request
        irq_in = 8'h10; cyc(); cyc();
        check("t4_id4", 32'(int_id), 32'd4);
        irq_in = 8'h12; cyc();
        check("t4_frozen_id", 32'(int_id), 32'd4);
        check("t4_frozen_INT", 32'(INT), 32'd1);
        pulse_ack();
        check("t4_ack_pending", 32'(pending), 32'h02);
        pulse_eoi(); cyc();
        check("t4_next_id", 32'(int_id), 32'd1);
        pulse_ack(); pulse_eoi(); irq_in = '0; cyc();

        // Set beats clear; stray eoi and ack are ignored
        irq_in = 8'h40; cyc(); cyc();
        check("t5_id6", 32'(int_id), 32'd6);
        pulse_eoi();
        check("t5_eoi_ignored", 32'(INT), 32'd1);
        irq_in = 8'h00; cyc();
        irq_in = 8'h40; pulse_ack();
        check("t5_set_wins", 32'(pending), 32'h40);
        check("t5_in_service", 32'(in_service), 32'd1);
        pulse_ack();
        check("t5_ack_ignored", 32'(in_service), 32'd1);
        pulse_eoi(); cyc();
        check("t5_repeat_INT", 32'(INT), 32'd1);
        pulse_ack();

        // Asynchronous reset during service
        check("t6_in_service", 32'(in_service), 32'd1);
        #2 rst = 1'b1; irq_in = 8'h01;
        #1;
        check("t6_async_INT", 32'(INT), 32'd0);
        check("t6_async_pending", 32'(pending), 32'd0);
        check("t6_async_in_service", 32'(in_service), 32'd0);
        cyc(); rst = 1'b0; cyc();
        check("t6_high_at_release", 32'(pending), 32'h01);
        cyc(); cyc();
        check("t6_mask_all", 32'(INT), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            irq_in  = irq_in ^ N'($urandom & $urandom & $urandom);
            mask_we = ($urandom_range(0, 7) == 0);
            mask_wdata = N'($urandom & $urandom);
            int_ack = ($urandom_range(0, 3) == 0);
            eoi     = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst = 1'b0; int_ack = 1'b0; eoi = 1'b0; mask_we = 1'b0;
        cyc(); cyc();

        done = 1;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
